bomb_timer_engine: RTL

BOMB_TIMER_ENGINE -- requirements
Module: bomb_timer_engine

---
 rtl/bomb_timer_engine.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bomb_timer_engine.sv
// Four-slot bomb fuse engine: counts ticks, detonates serially, resolves blast cross, chain reactions and hits.
// Latency: blast_valid one cycle after the fuse empties, hits one cycle later; place_ready low when full or blasting.
module bomb_timer_engine #(
    parameter int FUSE_TICKS = 3,
    parameter int RADIUS     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       place_valid,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    output logic       place_ready,
    output logic       place_drop,
    input  logic [3:0] playerAx,
    input  logic [3:0] playerAy,
    input  logic [3:0] playerBx,
    input  logic [3:0] playerBy,
    output logic       blast_valid,
    output logic [3:0] blast_x,
    output logic [3:0] blast_y,
    output logic       playerA_hit,
    output logic       playerB_hit,
    output logic [2:0] bomb_count
);
    typedef enum logic {IDLE = 1'b0, BLAST = 1'b1} state_t;

    localparam logic [3:0] RAD       = 4'(RADIUS);
    localparam logic [2:0] FUSE_INIT = 3'(FUSE_TICKS);
    localparam logic [3:0] MAX_CELL  = 4'd9;

    state_t     state;
    logic [3:0] active, pending, active_n, pending_n;
    logic [3:0] slot_x [4];
    logic [3:0] slot_y [4];
    logic [2:0] fuse   [4];
    logic [3:0] slot_x_n [4];
    logic [3:0] slot_y_n [4];
    logic [2:0] fuse_n   [4];
    logic       accept, reject, dup, has_free, has_pend;
    logic [1:0] free_idx, pend_idx;
    logic [2:0] count_n;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic in_cross(input logic [3:0] px, input logic [3:0] py,
                                      input logic [3:0] cx, input logic [3:0] cy);
        return (px <= MAX_CELL) && (py <= MAX_CELL) &&
               (((px == cx) && (abs_diff(py, cy) <= RAD)) ||
                ((py == cy) && (abs_diff(px, cx) <= RAD)));
    endfunction

    assign place_ready = (~&active) && (state == IDLE);

    always_comb begin
        active_n  = active;
        pending_n = pending;
        slot_x_n  = slot_x;
        slot_y_n  = slot_y;
        fuse_n    = fuse;
        has_free  = 1'b0;
        free_idx  = 2'd0;
        has_pend  = 1'b0;
        pend_idx  = 2'd0;
        dup       = 1'b0;
        count_n   = 3'd0;

        for (int i = 3; i >= 0; i--) begin
            if (!active[i]) begin
                has_free = 1'b1;
                free_idx = 2'(i);
            end
            if (pending[i]) begin
                has_pend = 1'b1;
                pend_idx = 2'(i);
            end
            if (active[i] && (slot_x[i] == place_x) && (slot_y[i] == place_y))
                dup = 1'b1;
        end

        accept = place_valid && place_ready;
        reject = accept && ((place_x > MAX_CELL) || (place_y > MAX_CELL) || dup);

        // Uses pre-edge active bits, so a slot loaded this cycle is never decremented.
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (active[i] && !pending[i] && (fuse[i] != 3'd0)) begin
                    fuse_n[i] = fuse[i] - 3'd1;
                    if (fuse[i] == 3'd1)
                        pending_n[i] = 1'b1;
                end
            end
        end

        if ((state == IDLE) && has_pend) begin
            active_n[pend_idx]  = 1'b0;
            pending_n[pend_idx] = 1'b0;
        end

        // Chain reaction: the detonated slot is already inactive, so only neighbours qualify.
        if (state == BLAST) begin
            for (int i = 0; i < 4; i++) begin
                if (active[i] && in_cross(slot_x[i], slot_y[i], blast_x, blast_y)) begin
                    pending_n[i] = 1'b1;
                    fuse_n[i]    = 3'd0;
                end
            end
        end

        if (accept && !reject && has_free) begin
            active_n[free_idx]  = 1'b1;
            pending_n[free_idx] = 1'b0;
            slot_x_n[free_idx]  = place_x;
            slot_y_n[free_idx]  = place_y;
            fuse_n[free_idx]    = FUSE_INIT;
        end

        for (int i = 0; i < 4; i++)
            count_n = count_n + {2'b00, active_n[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            active      <= 4'd0;
            pending     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                slot_x[i] <= 4'd0;
                slot_y[i] <= 4'd0;
                fuse[i]   <= 3'd0;
            end
            blast_valid <= 1'b0;
            blast_x     <= 4'd0;
            blast_y     <= 4'd0;
            place_drop  <= 1'b0;
            playerA_hit <= 1'b0;
            playerB_hit <= 1'b0;
            bomb_count  <= 3'd0;
        end else begin
            active     <= active_n;
            pending    <= pending_n;
            slot_x     <= slot_x_n;
            slot_y     <= slot_y_n;
            fuse       <= fuse_n;
            place_drop <= reject;
            bomb_count <= count_n;
            if (state == IDLE) begin
                if (has_pend) begin
                    blast_x     <= slot_x[pend_idx];
                    blast_y     <= slot_y[pend_idx];
                    blast_valid <= 1'b1;
                    state       <= BLAST;
                end
            end else begin
                blast_valid <= 1'b0;
                state       <= IDLE;
                if (in_cross(playerAx, playerAy, blast_x, blast_y))
                    playerA_hit <= 1'b1;
                if (in_cross(playerBx, playerBy, blast_x, blast_y))
                    playerB_hit <= 1'b1;
            end
        end
    end
endmodule
